dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sequences and shares the single data memory port between two requesters: the core's memory stage (LSU side) and an external burst master (loader/DMA/debug).
- Core accesses are single-beat and zero-latency. External accesses are multi-beat word bursts that own the memory for their full length.
- Core has priority. A starvation counter guarantees the external master a grant.
- Drives `stall_o` to freeze the pipeline while the core is denied.

Parameters:
- DW, 32, data/address width
- LENW, 4, width of burst-length field (max burst = 2^LENW - 1 beats)
- MAX_WAIT, 8, consecutive denied IDLE cycles before the external master is forced to win
- ADDENT, 4, address increment per burst beat

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core memory access request (load or store in M stage)
- core_we_i  in  1  core store
- core_mask_i  in  4  core byte mask
- core_addr_i  in  DW  core byte address
- core_wdata_i  in  DW  core store data
- core_gnt_o  out  1  core access performed this cycle
- core_rdata_o  out  DW  load data, valid when core_gnt_o
- stall_o  out  1  core_req_i & ~core_gnt_o
- ext_req_i  in  1  external burst request
- ext_we_i  in  1  burst is write
- ext_addr_i  in  DW  burst start address (bits [1:0] ignored, forced 0)
- ext_len_i  in  LENW  beat count; 0 treated as 1
- ext_wdata_i  in  DW  write data for current beat
- ext_gnt_o  out  1  one-cycle pulse: burst accepted, command latched
- ext_beat_o  out  1  a beat executes this cycle (write data consumed / read data valid)
- ext_rdata_o  out  DW  read data, valid with ext_beat_o & ~we
- ext_done_o  out  1  asserted with the final beat
- mem_we_o  out  1  data memory write enable
- mem_mask_o  out  4  byte mask
- mem_addr_o  out  DW  address
- mem_wdata_o  out  DW  write data
- mem_rdata_i  in  DW  memory read data (combinational read, synchronous write)

Behaviour:
- States: IDLE, BURST. Reset → IDLE, `wait_cnt` = 0, burst registers = 0.
- All outputs are 0 while rst_i is low and in IDLE with no requests.
- Reset asserted mid-burst aborts immediately:
  - no further mem_we_o;
  - no ext_done_o;
  - the master must reissue.
- IDLE arbitration, decided combinationally each cycle:
  - core_req_i alone → core wins.
  - ext_req_i alone → ext wins.
  - Both requesting:
    - ext wins if wait_cnt == MAX_WAIT;
    - otherwise core wins.
- Core win, same cycle:
  - core_gnt_o = 1;
  - mem_* driven from core_*;
  - core_rdata_o = mem_rdata_i;
  - state stays IDLE.
- Ext win:
  - ext_gnt_o = 1 for one cycle;
  - latch addr & ~3, we, len (0→1);
  - beat counter = 0;
  - next state BURST.
  - No memory access in the grant cycle; a simultaneous core request stalls.
- wait_cnt:
  - increments, saturating at MAX_WAIT, on each IDLE cycle with ext_req_i = 1 and no ext grant;
  - clears on ext grant or when ext_req_i = 0.
- BURST, one beat per cycle:
  - ext_beat_o = 1;
  - mem_addr_o = latched addr;
  - mem_we_o = latched we;
  - mem_mask_o = 4'hF;
  - mem_wdata_o = ext_wdata_i;
  - ext_rdata_o = mem_rdata_i.
- Each beat: addr += ADDENT (modulo 2^DW, wraps silently) and count += 1.
- On the beat where count == len-1: ext_done_o = 1, next state IDLE.
- ext_req_i is ignored during BURST; a new burst needs a fresh IDLE grant.
- Core is never granted in BURST: core_gnt_o = 0 and stall_o follows core_req_i.
- A core request held through a burst is served in the first IDLE cycle after it. Burst-to-next-burst therefore always leaves at least one IDLE cycle for the core.
- When idle with no grant, mem_we_o = 0; other mem_* are don't-care but driven 0.
- Latency:
  - core: 0 cycles;
  - ext: first beat 1 cycle after ext_gnt_o;
  - burst of N beats occupies N+1 cycles including grant.

Test Plan:
- Core only: core_req/we=1, addr 0x10, wdata 0xDEADBEEF, mask F; next cycle load 0x10 → core_gnt_o both cycles, stall_o = 0, core_rdata_o = 0xDEADBEEF.
- Ext write burst: addr 0x21, len 4, wdata 1,2,3,4 → ext_gnt_o pulse, then 4 beats at 0x20/24/28/2C, ext_done_o on 4th. Core reads of those addresses then return 1..4.
- Contention: core_req held, ext_req asserted during a 3-beat burst → stall_o high for grant+3 cycles. The core is granted the cycle after ext_done_o.
- Starvation: core_req and ext_req both held continuously, MAX_WAIT = 8 → core granted 8 cycles, ext granted in the 9th, core stalled for len+1 cycles.
- Edge cases:
  - len = 0 → exactly one beat with ext_done_o;
  - burst starting at 0xFFFFFFFC, len 2 → second beat addr 0x00000000.
- Reset mid-burst: drop rst_i during beat 2 of a 4-beat write → outputs 0 immediately, state IDLE, beats 3–4 never written, no ext_done_o.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, external-master and data-memory signals around dmem_arbiter.
// The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface dmem_arbiter_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned LENW = 4
);
  logic            core_req_i;
  logic            core_we_i;
  logic [3:0]      core_mask_i;
  logic [DW-1:0]   core_addr_i;
  logic [DW-1:0]   core_wdata_i;
  logic            core_gnt_o;
  logic [DW-1:0]   core_rdata_o;
  logic            stall_o;

  logic            ext_req_i;
  logic            ext_we_i;
  logic [DW-1:0]   ext_addr_i;
  logic [LENW-1:0] ext_len_i;
  logic [DW-1:0]   ext_wdata_i;
  logic            ext_gnt_o;
  logic            ext_beat_o;
  logic [DW-1:0]   ext_rdata_o;
  logic            ext_done_o;

  logic            mem_we_o;
  logic [3:0]      mem_mask_o;
  logic [DW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_mask_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rdata_o, stall_o,
    input  ext_req_i, ext_we_i, ext_addr_i, ext_len_i, ext_wdata_i,
    output ext_gnt_o, ext_beat_o, ext_rdata_o, ext_done_o,
    output mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_mask_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rdata_o, stall_o,
    output ext_req_i, ext_we_i, ext_addr_i, ext_len_i, ext_wdata_i,
    input  ext_gnt_o, ext_beat_o, ext_rdata_o, ext_done_o,
    input  mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (single beat, priority) and an
// external burst master, with a starvation counter that eventually forces an external grant.
module dmem_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned LENW     = 4,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned ADDENT   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          r_state, w_state_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic [DW-1:0]   r_addr, w_addr_nxt;
  logic            r_we, w_we_nxt;
  logic [LENW-1:0] r_len, w_len_nxt;
  logic [LENW-1:0] r_cnt, w_cnt_nxt;

  logic            w_ext_win, w_core_win;
  logic            w_core_gnt, w_stall, w_ext_gnt, w_ext_beat, w_ext_done, w_mem_we;
  logic [3:0]      w_mem_mask;
  logic [DW-1:0]   w_core_rdata, w_ext_rdata, w_mem_addr, w_mem_wdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_wait  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_addr_nxt   = r_addr;
    w_we_nxt     = r_we;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_ext_win    = 1'b0;
    w_core_win   = 1'b0;
    w_core_gnt   = 1'b0;
    w_stall      = 1'b0;
    w_ext_gnt    = 1'b0;
    w_ext_beat   = 1'b0;
    w_ext_done   = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_mask   = 4'h0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_core_rdata = '0;
    w_ext_rdata  = '0;
    // Outputs are forced low for the whole time reset is held, including mid-burst.
    if (rst_i) begin
      unique case (r_state)
        StIdle: begin
          w_ext_win  = bus.ext_req_i & (~bus.core_req_i | (r_wait == WW'(MAX_WAIT)));
          w_core_win = bus.core_req_i & ~w_ext_win;
          if (w_core_win) begin
            w_core_gnt   = 1'b1;
            w_mem_we     = bus.core_we_i;
            w_mem_mask   = bus.core_mask_i;
            w_mem_addr   = bus.core_addr_i;
            w_mem_wdata  = bus.core_wdata_i;
            w_core_rdata = bus.mem_rdata_i;
          end
          if (w_ext_win) begin
            w_ext_gnt   = 1'b1;
            w_addr_nxt  = bus.ext_addr_i & ~DW'(3);
            w_we_nxt    = bus.ext_we_i;
            w_len_nxt   = (bus.ext_len_i == '0) ? LENW'(1) : bus.ext_len_i;
            w_cnt_nxt   = '0;
            w_wait_nxt  = '0;
            w_state_nxt = StBurst;
          end else if (bus.ext_req_i) begin
            w_wait_nxt = (r_wait == WW'(MAX_WAIT)) ? r_wait : r_wait + WW'(1);
          end else begin
            w_wait_nxt = '0;
          end
        end
        StBurst: begin
          w_ext_beat  = 1'b1;
          w_mem_we    = r_we;
          w_mem_mask  = 4'hF;
          w_mem_addr  = r_addr;
          w_mem_wdata = bus.ext_wdata_i;
          w_ext_rdata = bus.mem_rdata_i;
          w_addr_nxt  = r_addr + DW'(ADDENT);
          w_cnt_nxt   = r_cnt + LENW'(1);
          if (r_cnt == r_len - LENW'(1)) begin
            w_ext_done  = 1'b1;
            w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
      w_stall = bus.core_req_i & ~w_core_gnt;
    end
  end

  assign bus.core_gnt_o   = w_core_gnt;
  assign bus.core_rdata_o = w_core_rdata;
  assign bus.stall_o      = w_stall;
  assign bus.ext_gnt_o    = w_ext_gnt;
  assign bus.ext_beat_o   = w_ext_beat;
  assign bus.ext_rdata_o  = w_ext_rdata;
  assign bus.ext_done_o   = w_ext_done;
  assign bus.mem_we_o     = w_mem_we;
  assign bus.mem_mask_o   = w_mem_mask;
  assign bus.mem_addr_o   = w_mem_addr;
  assign bus.mem_wdata_o  = w_mem_wdata;

endmodule
